// File: rtl/lisnoc_converter_upsize_pkg.sv
// Shared definitions for the narrow-to-wide LISNoC flit converter:
// flit type codes, FSM state codes, class field size and type helpers.
package lisnoc_converter_upsize_pkg;

    typedef logic [1:0] flit_type_t;

    localparam flit_type_t FLIT_PAYLOAD = 2'b00;
    localparam flit_type_t FLIT_HEADER  = 2'b01;
    localparam flit_type_t FLIT_LAST    = 2'b10;
    localparam flit_type_t FLIT_SINGLE  = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

    // Packet class lives in the top bits of the narrow header data.
    localparam int CLASS_BITS  = 3;
    localparam int QUEUE_DEPTH = 2;

    function automatic logic is_end(input flit_type_t t);
        return (t == FLIT_LAST) || (t == FLIT_SINGLE);
    endfunction

    function automatic flit_type_t wide_type(input logic first, input logic last);
        if (first) return last ? FLIT_SINGLE : FLIT_HEADER;
        return last ? FLIT_LAST : FLIT_PAYLOAD;
    endfunction

endpackage

// File: rtl/lisnoc_converter_upsize_fifo.sv
// Two-entry output queue for wide flits; head entry is held stable until popped.
module lisnoc_converter_upsize_fifo
    import lisnoc_converter_upsize_pkg::*;
#(
    parameter int width = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head_data,
    output logic             empty,
    output logic             full
);

    logic [width-1:0] mem [QUEUE_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == 2'd0);
    assign full      = (count == 2'(QUEUE_DEPTH));

endmodule

// File: rtl/lisnoc_converter_upsize.sv
// Packs ratio narrow flits of one packet into one wide flit, regenerating flit
// types, zero-padding short tails and discarding packets of a foreign class.
//
// state       | meaning
// ST_IDLE     | waiting for a packet start; stray flits are discarded
// ST_COLLECT  | filling lanes of the current wide flit
// ST_DROP     | discarding a class-mismatch packet up to its LAST
module lisnoc_converter_upsize
    import lisnoc_converter_upsize_pkg::*;
#(
    parameter int         narrow_width  = 16,
    parameter int         ratio         = 2,
    parameter int         vchannels_in  = 1,
    parameter int         vchannels_out = 3,
    parameter int         out_vchannel  = 0,
    parameter logic [2:0] packet_class  = 3'h0,
    parameter bit         strip_header  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [narrow_width+1:0]       in_flit,
    input  logic [vchannels_in-1:0]       in_valid,
    output logic [vchannels_in-1:0]       in_ready,
    output logic [narrow_width*ratio+1:0] out_flit,
    output logic [vchannels_out-1:0]      out_valid,
    input  logic [vchannels_out-1:0]      out_ready,
    output logic                          drop_pulse
);

    localparam int W  = narrow_width * ratio;
    localparam int LW = $clog2(ratio);
    localparam int VW = (vchannels_in > 1) ? $clog2(vchannels_in) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(ratio - 1);

    logic [1:0]              state;
    logic [LW-1:0]           lane;
    logic                    first_wide;
    logic [W-1:0]            lane_data;
    logic                    locked;
    logic [VW-1:0]           lock_vc;
    logic [VW-1:0]           rr_ptr;
    logic [VW-1:0]           sel_vc;

    flit_type_t              in_type;
    logic [narrow_width-1:0] in_data;
    logic                    in_end;
    logic                    class_ok;
    logic                    completing;
    logic                    can_accept;
    logic                    accept;
    logic                    write_lane;
    logic [LW-1:0]           wr_lane;

    logic                    q_push;
    logic [W+1:0]            q_push_data;
    logic [W-1:0]            wide_data;
    logic                    q_pop;
    logic                    q_empty;
    logic                    q_full;
    logic                    unused_ready;

    assign in_type  = in_flit[narrow_width+1 -: 2];
    assign in_data  = in_flit[narrow_width-1:0];
    assign in_end   = is_end(in_type);
    assign class_ok = (in_data[narrow_width-1 -: CLASS_BITS] == packet_class);

    // Round-robin starting after the last packet's VC; held while a packet is open.
    always_comb begin
        sel_vc = rr_ptr;
        if (locked) begin
            sel_vc = lock_vc;
        end else begin
            for (int i = vchannels_in; i >= 1; i--) begin
                if (in_valid[VW'((int'(rr_ptr) + i) % vchannels_in)])
                    sel_vc = VW'((int'(rr_ptr) + i) % vchannels_in);
            end
        end
    end

    // Only a flit that closes a wide flit needs queue space; full comes from a register.
    assign completing = (state == ST_COLLECT) && ((lane == LAST_LANE) || in_end);
    assign can_accept = !completing || !q_full;
    assign accept     = rst_n && can_accept && in_valid[sel_vc];

    always_comb begin
        in_ready = '0;
        if (rst_n && can_accept) in_ready[sel_vc] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            lane       <= '0;
            first_wide <= 1'b0;
            locked     <= 1'b0;
            lock_vc    <= '0;
            rr_ptr     <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            if (accept) begin
                if (!locked) begin
                    rr_ptr  <= sel_vc;
                    lock_vc <= sel_vc;
                end
                locked <= !in_end;
                case (state)
                    ST_IDLE: begin
                        if (in_type == FLIT_HEADER) begin
                            if (class_ok) begin
                                state      <= ST_COLLECT;
                                first_wide <= 1'b1;
                                lane       <= strip_header ? '0 : LW'(1);
                            end else begin
                                state <= ST_DROP;
                            end
                        end else if (in_type == FLIT_SINGLE) begin
                            drop_pulse <= 1'b1;
                        end
                    end
                    ST_COLLECT: begin
                        if (completing) begin
                            lane       <= '0;
                            first_wide <= 1'b0;
                            if (in_end) state <= ST_IDLE;
                        end else begin
                            lane <= lane + LW'(1);
                        end
                    end
                    ST_DROP: begin
                        if (in_end) begin
                            drop_pulse <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign write_lane = accept &&
                        (((state == ST_COLLECT) && !completing) ||
                         ((state == ST_IDLE) && !strip_header &&
                          (in_type == FLIT_HEADER) && class_ok));
    assign wr_lane    = (state == ST_IDLE) ? '0 : lane;

    // Lane storage is not reset; the push mux only ever reads lanes already written.
    always_ff @(posedge clk) begin
        if (write_lane) begin
            for (int i = 0; i < ratio; i++) begin
                if (LW'(i) == wr_lane) lane_data[W-1-i*narrow_width -: narrow_width] <= in_data;
            end
        end
    end

    // Lane 0 is the most significant slice; lanes past the current one are zero.
    always_comb begin
        wide_data = '0;
        for (int i = 0; i < ratio; i++) begin
            if (LW'(i) < lane)
                wide_data[W-1-i*narrow_width -: narrow_width] = lane_data[W-1-i*narrow_width -: narrow_width];
            else if (LW'(i) == lane)
                wide_data[W-1-i*narrow_width -: narrow_width] = in_data;
        end
    end

    assign q_push      = accept && completing;
    assign q_push_data = {wide_type(first_wide, in_end), wide_data};
    assign q_pop       = rst_n && !q_empty && out_ready[out_vchannel];

    lisnoc_converter_upsize_fifo #(
        .width (W + 2)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head_data (out_flit),
        .empty     (q_empty),
        .full      (q_full)
    );

    always_comb begin
        out_valid = '0;
        out_valid[out_vchannel] = rst_n && !q_empty;
    end

    assign unused_ready = ^out_ready;

endmodule
